// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Round-robin arbiter that shares one i2c_master between NUM_REQ requesters.
//   A winner's chip/register address, data and write mode are latched onto the
//   m_* bus, a single-cycle we/re strobe is issued, and the master's busy flag
//   is tracked to completion. Read data, status and a timeout error are then
//   returned to the winner together with a one-cycle req_done pulse.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req[NUM_REQ]          level request, held until the matching req_done
//   req_rnw               1 = read, 0 = write (per requester)
//   req_write_mode        forwarded to m_write_mode (per requester)
//   req_chip_addr         7 bits per requester, packed
//   req_reg_addr          AW bits per requester, packed
//   req_datai             DW bits per requester, packed
//   req_grant             one-hot owner of the master
//   req_done              one-cycle completion pulse to the owner
//   req_datao/status/err  results captured at completion
//   m_*                   connection to i2c_master
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_ADDR_BYTES = 1,
  parameter int NUM_DATA_BYTES = 2,
  parameter int START_TIMEOUT  = 15,
  localparam int AW = 8 * NUM_ADDR_BYTES,
  localparam int DW = 8 * NUM_DATA_BYTES,
  localparam int LW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rnw,
  input  logic [NUM_REQ-1:0]    req_write_mode,
  input  logic [7*NUM_REQ-1:0]  req_chip_addr,
  input  logic [AW*NUM_REQ-1:0] req_reg_addr,
  input  logic [DW*NUM_REQ-1:0] req_datai,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [DW-1:0]         req_datao,
  output logic [3:0]            req_status,
  output logic                  req_err,
  output logic [6:0]            m_chip_addr,
  output logic [AW-1:0]         m_reg_addr,
  output logic [DW-1:0]         m_datai,
  output logic                  m_write_mode,
  output logic                  m_we,
  output logic                  m_re,
  input  logic                  m_busy,
  input  logic [3:0]            m_status,
  input  logic [DW-1:0]         m_datao
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_END, COMPLETE} state_t;

  state_t        state;
  logic [LW-1:0] last;
  logic [LW-1:0] cur_idx;
  logic          cur_rnw;
  logic [3:0]    to_cnt;

  // Round-robin search starting one past the last winner.
  logic          win_vld;
  logic [LW-1:0] win_idx;
  logic [LW-1:0] cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = LW'((int'(last) + i) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last         <= LW'(NUM_REQ - 1);
      cur_idx      <= '0;
      cur_rnw      <= 1'b0;
      to_cnt       <= '0;
      req_grant    <= '0;
      req_done     <= '0;
      req_datao    <= '0;
      req_status   <= '0;
      req_err      <= 1'b0;
      m_chip_addr  <= '0;
      m_reg_addr   <= '0;
      m_datai      <= '0;
      m_write_mode <= 1'b0;
      m_we         <= 1'b0;
      m_re         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            req_grant    <= NUM_REQ'(1) << win_idx;
            m_chip_addr  <= req_chip_addr[int'(win_idx)*7 +: 7];
            m_reg_addr   <= req_reg_addr[int'(win_idx)*AW +: AW];
            m_datai      <= req_datai[int'(win_idx)*DW +: DW];
            m_write_mode <= req_write_mode[win_idx];
            cur_rnw      <= req_rnw[win_idx];
            cur_idx      <= win_idx;
            last         <= win_idx;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          m_re   <= cur_rnw;
          m_we   <= !cur_rnw;
          to_cnt <= '0;
          state  <= WAIT_START;
        end
        WAIT_START: begin
          m_we <= 1'b0;
          m_re <= 1'b0;
          if (m_busy) begin
            state <= WAIT_END;
          end else if (to_cnt == 4'(START_TIMEOUT)) begin
            // Master never started: finish with the error flag set.
            if (cur_rnw) req_datao <= m_datao;
            req_status <= m_status;
            req_err    <= 1'b1;
            req_done   <= NUM_REQ'(1) << cur_idx;
            req_grant  <= '0;
            state      <= COMPLETE;
          end else if (!(m_we || m_re)) begin
            // The strobe cycle itself is not counted; the master cannot
            // have reacted yet.
            to_cnt <= to_cnt + 4'd1;
          end
        end
        WAIT_END: begin
          if (!m_busy) begin
            if (cur_rnw) req_datao <= m_datao;
            req_status <= m_status;
            req_err    <= 1'b0;
            req_done   <= NUM_REQ'(1) << cur_idx;
            req_grant  <= '0;
            state      <= COMPLETE;
          end
        end
        COMPLETE: begin
          // req_done is visible during this cycle; the following IDLE cycle
          // gives the requester time to drop or re-raise req.
          req_done <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter that shares one `i2c_master` between `NUM_REQ` independent requesters (register-map shadows, sensor pollers, firmware bridge). It accepts level-held transaction requests and latches the winning requester's address, data and mode. It then issues a single-cycle `we`/`re` strobe to the master and tracks `busy` to completion. Read data, status and a one-cycle done pulse are returned to the granted requester. The block sits directly in front of `i2c_master`; `clk_divider` and `open_drain_mode` are wired around it.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- NUM_ADDR_BYTES, 1, register address bytes; AW = 8*NUM_ADDR_BYTES
- NUM_DATA_BYTES, 2, data bytes; DW = 8*NUM_DATA_BYTES
- START_TIMEOUT, 15, cycles after the strobe within which `m_busy` must rise (4-bit counter)

Ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level, held until that requester's `req_done` pulse
- req_rnw  in  NUM_REQ  1 = read, 0 = write
- req_write_mode  in  NUM_REQ  forwarded to master `write_mode`
- req_chip_addr  in  7*NUM_REQ  packed; requester i uses bits [7i+6:7i]
- req_reg_addr  in  AW*NUM_REQ  packed per requester
- req_datai  in  DW*NUM_REQ  packed per requester
- req_grant  out  NUM_REQ  one-hot; the requester currently owning the master
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_datao  out  DW  read data captured at completion, held until the next completion
- req_status  out  4  master `status` captured at completion
- req_err  out  1  captured at completion; 1 = master never went busy
- m_chip_addr  out  7  to master `chip_addr`
- m_reg_addr  out  AW  to master `reg_addr`
- m_datai  out  DW  to master `datai`
- m_write_mode  out  1  to master `write_mode`
- m_we  out  1  to master `we`
- m_re  out  1  to master `re`
- m_busy  in  1  from master `busy`
- m_status  in  4  from master `status`
- m_datao  in  DW  from master `datao`

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_END, COMPLETE.
- IDLE: when any `req` bit is high, select the winner by round robin. The search starts at `last+1` and wraps modulo NUM_REQ. `last` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- On selection: register the one-hot `req_grant`, latch the winner's fields into `m_*`, update `last`, go to ISSUE.
- ISSUE: assert `m_re` (rnw=1) or `m_we` (rnw=0) for exactly one cycle, clear the timeout counter, go to WAIT_START.
- WAIT_START:
  - `m_busy`=1 → WAIT_END.
  - Counter reaches START_TIMEOUT → set the internal err flag, go to COMPLETE.
- WAIT_END: `m_busy`=0 → COMPLETE.
- COMPLETE:
  - Capture `m_datao` into `req_datao` (reads only; writes leave it unchanged).
  - Capture `m_status` into `req_status` and the err flag into `req_err`.
  - Pulse `req_done[winner]`, clear `req_grant`, return to IDLE.
- `m_*` fields stay frozen from grant until the next grant; requester input changes during a transaction are ignored.
- A requester still holding `req` in the cycle after its `req_done` is treated as a new request, but only wins when its round-robin turn comes.
- A `req` bit dropped before it is granted withdraws that request. Dropping `req` after grant does not abort the transaction.
- `m_we` and `m_re` are never high together.
- Reset (asynchronous, any state): FSM → IDLE, `last` = NUM_REQ-1. All outputs → 0, including `req_grant`, `req_done`, `req_datao`, `req_status`, `req_err`, `m_we`, `m_re` and all `m_*` fields. No done pulse is produced for an aborted transaction.

## Timing
- All outputs are registered.
- Cycle 0: `req` seen in IDLE. Cycle 1: `req_grant` and `m_*` valid. Cycle 2: `m_we`/`m_re` high. Cycle 3 onward: WAIT_START.
- `req_done` is high in the cycle after the first cycle `m_busy` is observed low in WAIT_END. `req_datao`/`req_status`/`req_err` are valid in that same cycle.
- Timeout path: `req_done` follows the strobe by START_TIMEOUT+2 cycles.
- Back-to-back: minimum 1 IDLE cycle between `req_done` and the next `req_grant`.

## Test plan
- Single write: `req[0]`=1, rnw=0, chip 0x70, reg 0x55, data 0xAAC3 → one `m_we` pulse carrying those values, a single `req_done[0]` pulse, and `req_err`=0. A slave model then reports reg 0x55 = 0xAAC3.
- Read-back: `req[2]` read of reg 0x55 → `m_re` pulse, then `req_done[2]` with `req_datao`=0xAAC3.
- Simultaneous: `req[0]` and `req[1]` raised in the same cycle after reset → requester 0 is served first and requester 1 second. There is no overlap in `m_busy`, and exactly one `req_grant` bit is high at a time.
- Fairness: all 4 requesters hold `req` continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Stall: master replaced by a stub with `m_busy` stuck at 0 → `req_done` 17 cycles after the strobe, with `req_err`=1. The next request then proceeds normally.
- Reset mid-transfer: assert `reset_n`=0 during WAIT_END → all outputs 0 immediately, with no `req_done` pulse. After release, a pending `req[3]` alone is granted in cycle 1.
